// File: rtl/psram_responder_pkg.sv
// Shared types for the asynchronous-mode PSRAM responder model.
package rv32i;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACTIVE,
    ST_WRITE,
    ST_READ_WAIT,
    ST_READ_DRIVE
  } psram_rsp_state_t;

  localparam int CRAM_DQ_W   = 16;
  localparam int CRAM_ADDR_W = 22;

  // Lanes whose active-low byte enable is high read back as zero.
  function automatic logic [CRAM_DQ_W-1:0] mask_bytes(input logic [CRAM_DQ_W-1:0] word,
                                                      input logic ub_n,
                                                      input logic lb_n);
    return {ub_n ? 8'h00 : word[15:8], lb_n ? 8'h00 : word[7:0]};
  endfunction

endpackage

// File: rtl/psram_responder_if.sv
// Cellular-RAM control/address bus (dq is carried separately as a tristate port).
interface psram_responder_if;
  logic [21:16] cram_a;
  logic         cram_adv_n;
  logic         cram_ce0_n;
  logic         cram_ce1_n;
  logic         cram_oe_n;
  logic         cram_we_n;
  logic         cram_ub_n;
  logic         cram_lb_n;
  logic         cram_clk;
  logic         cram_cre;
  logic         cram_wait;

  modport master (
    output cram_a, cram_adv_n, cram_ce0_n, cram_ce1_n, cram_oe_n, cram_we_n,
    output cram_ub_n, cram_lb_n, cram_clk, cram_cre,
    input  cram_wait
  );

  modport slave (
    input  cram_a, cram_adv_n, cram_ce0_n, cram_ce1_n, cram_oe_n, cram_we_n,
    input  cram_ub_n, cram_lb_n, cram_clk, cram_cre,
    output cram_wait
  );
endinterface

// File: rtl/psram_responder_mem.sv
// 2^ADDR_WIDTH x 16 storage split into two byte lanes, each with its own write enable.
module psram_responder_mem #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [1:0]            we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [15:0]           wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [15:0]           rdata_o
);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic [7:0] mem_q [0:(1<<ADDR_WIDTH)-1];
      logic [7:0] rd_q;

      always_ff @(posedge clk) begin
        if (we_i[gi]) begin
          mem_q[waddr_i] <= wdata_i[gi*8 +: 8];
        end
        rd_q <= mem_q[raddr_i];
      end

      assign rdata_o[gi*8 +: 8] = rd_q;
    end
  endgenerate

endmodule

// File: rtl/psram_responder.sv
// Asynchronous-mode PSRAM responder: muxed address/data bus, byte-masked storage, fixed read latency.
// Optional protocol checker enabled by defining PSRAM_RESPONDER_CHECK_EN.
module psram_responder
  import rv32i::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 4,
  parameter int BANK         = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  psram_responder_if.slave     cram,
  inout  wire [CRAM_DQ_W-1:0]  cram_dq,
  output logic                 busy,
  output logic                 violation
);

  localparam int CNT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LATENCY - 1);

  logic [21:16]          a_q;
  logic [CRAM_DQ_W-1:0]  dq_in_q;
  logic                  adv_n_q, ce0_n_q, ce1_n_q, oe_n_q, we_n_q;
  logic                  ub_n_q, lb_n_q, clk_in_q, cre_q;

  // Every bus input passes through one register; the FSM only sees these copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '1;
      dq_in_q  <= '1;
      adv_n_q  <= 1'b1;
      ce0_n_q  <= 1'b1;
      ce1_n_q  <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      clk_in_q <= 1'b1;
      cre_q    <= 1'b1;
    end else begin
      a_q      <= cram.cram_a;
      dq_in_q  <= cram_dq;
      adv_n_q  <= cram.cram_adv_n;
      ce0_n_q  <= cram.cram_ce0_n;
      ce1_n_q  <= cram.cram_ce1_n;
      oe_n_q   <= cram.cram_oe_n;
      we_n_q   <= cram.cram_we_n;
      ub_n_q   <= cram.cram_ub_n;
      lb_n_q   <= cram.cram_lb_n;
      clk_in_q <= cram.cram_clk;
      cre_q    <= cram.cram_cre;
    end
  end

  logic                   sel_ce_n;
  logic [CRAM_ADDR_W-1:0] full_addr;
  assign sel_ce_n  = (BANK == 1) ? ce1_n_q : ce0_n_q;
  assign full_addr = {a_q, dq_in_q};

  psram_rsp_state_t       state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CRAM_DQ_W-1:0]   wdata_q, wdata_d;
  logic [1:0]             wbe_n_q, wbe_n_d;
  logic                   dq_oe_q;
  logic                   commit;
  logic [CRAM_DQ_W-1:0]   rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wbe_n_d = wbe_n_q;
    commit  = 1'b0;

    if (sel_ce_n) begin
      state_d = ST_IDLE;
    end else if (!adv_n_q && (state_q != ST_IDLE || !cre_q)) begin
      state_d = ST_ADDR;
    end else begin
      unique case (state_q)
        ST_IDLE:       state_d = ST_IDLE;
        ST_ADDR:       state_d = ST_ACTIVE;
        ST_ACTIVE: begin
          if (!we_n_q) begin
            state_d = ST_WRITE;
          end else if (!oe_n_q) begin
            state_d = ST_READ_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_WRITE: begin
          if (we_n_q) state_d = ST_ACTIVE;
        end
        ST_READ_WAIT: begin
          if (oe_n_q) begin
            state_d = ST_ACTIVE;
          end else if (cnt_q >= CNT_LAST) begin
            state_d = ST_READ_DRIVE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_READ_DRIVE: begin
          if (oe_n_q) state_d = ST_ACTIVE;
        end
        default:       state_d = ST_IDLE;
      endcase
    end

    if (state_d == ST_ADDR) begin
      addr_d = full_addr[ADDR_WIDTH-1:0];
    end
    if (state_d == ST_WRITE) begin
      wdata_d = dq_in_q;
      wbe_n_d = {ub_n_q, lb_n_q};
    end
    // Leaving WRITE through we_n/CE rise commits; leaving through a new adv_n pulse drops it.
    commit = (state_q == ST_WRITE) && (state_d == ST_ACTIVE || state_d == ST_IDLE) && !dq_oe_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wbe_n_q <= 2'b11;
      dq_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wbe_n_q <= wbe_n_d;
      dq_oe_q <= (state_d == ST_READ_DRIVE);
    end
  end

  psram_responder_mem #(.ADDR_WIDTH(ADDR_WIDTH)) u_mem (
    .clk     (clk),
    .we_i    (commit ? ~wbe_n_q : 2'b00),
    .waddr_i (addr_q),
    .wdata_i (wdata_q),
    .raddr_i (addr_q),
    .rdata_o (rdata)
  );

  assign cram_dq        = dq_oe_q ? mask_bytes(rdata, ub_n_q, lb_n_q) : {CRAM_DQ_W{1'bz}};
  assign busy           = (state_q != ST_IDLE);
  assign cram.cram_wait = 1'b0;

  logic unused_ok;
  assign unused_ok = &{1'b0, clk_in_q, ce0_n_q, ce1_n_q, full_addr};

`ifdef PSRAM_RESPONDER_CHECK_EN
  logic       adv_prev_q;
  logic [1:0] adv_len_q;
  logic       viol_q;

  // adv_len_q saturates at 3; a rising adv_n with fewer than 2 low samples is a runt pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adv_prev_q <= 1'b1;
      adv_len_q  <= '0;
      viol_q     <= 1'b0;
    end else begin
      adv_prev_q <= adv_n_q;
      if (!adv_n_q) begin
        adv_len_q <= adv_prev_q ? 2'd1 : ((adv_len_q == 2'd3) ? 2'd3 : adv_len_q + 2'd1);
      end
      if (!sel_ce_n && !oe_n_q && !we_n_q) viol_q <= 1'b1;
      if (!sel_ce_n && adv_n_q && !adv_prev_q && (adv_len_q < 2'd2)) viol_q <= 1'b1;
      if ((state_q == ST_READ_DRIVE) && !oe_n_q && !we_n_q) viol_q <= 1'b1;
    end
  end

  assign violation = viol_q;
`else
  assign violation = 1'b0;
`endif

endmodule

// File: tb/tb_psram_responder.sv
// Directed bench for psram_responder: a word-level model feeds a scoreboard queue of read results.
module tb_psram_responder;
  localparam int AW = 10;
  localparam int RL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  psram_responder_if bus();
  wire  [15:0] cram_dq;
  logic [15:0] tb_dq = '0;
  logic        tb_dq_en = 1'b0;
  assign cram_dq = tb_dq_en ? tb_dq : 16'bz;

  logic busy;
  logic violation;

  psram_responder #(.ADDR_WIDTH(AW), .READ_LATENCY(RL), .BANK(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cram      (bus),
    .cram_dq   (cram_dq),
    .busy      (busy),
    .violation (violation)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] model [0:(1<<AW)-1];
  logic [15:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic idle_bus();
    bus.cram_a     = '0;
    bus.cram_adv_n = 1'b1;
    bus.cram_ce0_n = 1'b1;
    bus.cram_ce1_n = 1'b1;
    bus.cram_oe_n  = 1'b1;
    bus.cram_we_n  = 1'b1;
    bus.cram_ub_n  = 1'b1;
    bus.cram_lb_n  = 1'b1;
    bus.cram_clk   = 1'b0;
    bus.cram_cre   = 1'b0;
    tb_dq_en       = 1'b0;
  endtask

  task automatic addr_phase(input logic [21:0] addr, input bit use_ce1, input bit cre);
    bus.cram_a     = addr[21:16];
    tb_dq          = addr[15:0];
    tb_dq_en       = 1'b1;
    bus.cram_cre   = cre;
    bus.cram_adv_n = 1'b0;
    if (use_ce1) bus.cram_ce1_n = 1'b0;
    else         bus.cram_ce0_n = 1'b0;
    cyc(2);
    bus.cram_adv_n = 1'b1;
  endtask

  task automatic do_write(input logic [21:0] addr, input logic [15:0] data,
                          input logic ub_n, input logic lb_n, input bit use_ce1);
    logic [AW-1:0] idx;
    idx = addr[AW-1:0];
    addr_phase(addr, use_ce1, 1'b0);
    tb_dq         = data;
    bus.cram_ub_n = ub_n;
    bus.cram_lb_n = lb_n;
    bus.cram_we_n = 1'b0;
    cyc(4);
    check("write busy", busy, use_ce1 ? 32'd0 : 32'd1);
    if (use_ce1) check("ce1 dq_oe", dut.dq_oe_q, 0);
    bus.cram_we_n = 1'b1;
    cyc(2);
    idle_bus();
    cyc(3);
    if (!use_ce1) begin
      model[idx] = {ub_n ? model[idx][15:8] : data[15:8], lb_n ? model[idx][7:0] : data[7:0]};
    end
    $display("write addr=%06h data=%04h ub_n=%b lb_n=%b ce%0d", addr, data, ub_n, lb_n, use_ce1 ? 1 : 0);
  endtask

  task automatic do_read(input logic [21:0] addr, input logic ub_n, input logic lb_n, input string tag);
    logic [15:0] w;
    logic [15:0] got;
    int k;
    addr_phase(addr, 1'b0, 1'b0);
    tb_dq_en      = 1'b0;
    bus.cram_ub_n = ub_n;
    bus.cram_lb_n = lb_n;
    cyc(2);
    w = model[addr[AW-1:0]];
    exp_q.push_back({ub_n ? 8'h00 : w[15:8], lb_n ? 8'h00 : w[7:0]});
    bus.cram_oe_n = 1'b0;
    k = 0;
    do begin
      cyc(1);
      k++;
    end while (!dut.dq_oe_q && k < 20);
    check({tag, " latency"}, k, RL + 1);
    got = cram_dq;
    check({tag, " data"}, got, exp_q.pop_front());
    bus.cram_oe_n = 1'b1;
    cyc(1);
    check({tag, " hold"}, dut.dq_oe_q, 1);
    cyc(1);
    check({tag, " release"}, dut.dq_oe_q, 0);
    idle_bus();
    cyc(3);
    $display("read  addr=%06h ub_n=%b lb_n=%b data=%04h cycles=%0d", addr, ub_n, lb_n, got, k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_bus();
    rst_n = 1'b0;
    cyc(2);
    check("reset busy", busy, 0);
    check("reset violation", violation, 0);
    check("reset dq_oe", dut.dq_oe_q, 0);
    check("reset wait", bus.cram_wait, 0);
    rst_n = 1'b1;
    cyc(2);
    check("idle busy", busy, 0);

    do_write(22'h000123, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    do_read (22'h000123, 1'b0, 1'b0, "rd_beef");
    do_write(22'h000123, 16'h1234, 1'b0, 1'b1, 1'b0);
    do_read (22'h000123, 1'b0, 1'b0, "rd_ub_only");
    do_read (22'h000123, 1'b1, 1'b0, "rd_lb_lane");
    do_write(22'h000123, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    do_read (22'h000123, 1'b0, 1'b0, "rd_no_lanes");

    // Reset lands while a write of 0x5555 is sampling.
    do_write(22'h000010, 16'h1111, 1'b0, 1'b0, 1'b0);
    addr_phase(22'h000010, 1'b0, 1'b0);
    tb_dq         = 16'h5555;
    bus.cram_ub_n = 1'b0;
    bus.cram_lb_n = 1'b0;
    bus.cram_we_n = 1'b0;
    cyc(4);
    check("mid-write busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async reset busy", busy, 0);
    check("async reset dq_oe", dut.dq_oe_q, 0);
    idle_bus();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    $display("reset during write addr=000010 data=5555");
    do_read (22'h000010, 1'b0, 1'b0, "rd_after_reset");

    do_write(22'h000010, 16'hAAAA, 1'b0, 1'b0, 1'b1);
    do_read (22'h000010, 1'b0, 1'b0, "rd_after_ce1");

    do_write(22'h000400, 16'h0A0A, 1'b0, 1'b0, 1'b0);
    do_read (22'h000000, 1'b0, 1'b0, "rd_alias");
    do_write(22'h010005, 16'h5A5A, 1'b0, 1'b0, 1'b0);
    do_read (22'h000005, 1'b0, 1'b0, "rd_alias_hi");

    addr_phase(22'h000020, 1'b0, 1'b1);
    cyc(2);
    check("cre busy", busy, 0);
    idle_bus();
    cyc(2);
    $display("cre transaction addr=000020");
    check("violation clean", violation, 0);

`ifdef PSRAM_RESPONDER_CHECK_EN
    addr_phase(22'h000030, 1'b0, 1'b0);
    tb_dq_en = 1'b0;
    cyc(2);
    bus.cram_oe_n = 1'b0;
    bus.cram_we_n = 1'b0;
    cyc(3);
    check("oe_we overlap violation", violation, 1);
    idle_bus();
    cyc(3);
    check("violation sticky", violation, 1);
    rst_n = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    check("violation reset", violation, 0);
    $display("overlap transaction addr=000030 oe_n=0 we_n=0");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
